clip_sequencer: RTL and testbench

- Parametrised record/playback controller for a multi-clip audio recorder: NUM_CLIPS clips, each backed by its own single-port sample memory.
- Sits between the synchronised user commands, the PDM deserializer, the PWM serializer and the clip memories.
- Replaces the fixed two-clip controller/timer/counter arrangement.
- Adds per-clip recorded-length tracking, playback that stops at the recorded length, loop mode, stop command and clip-valid flags.

---
 rtl/clip_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_clip_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clip_sequencer.sv
// Record/playback sequencer for NUM_CLIPS audio clips, each in its own single-port memory.
// Tracks each clip's recorded length and stops or loops playback at that length.
module clip_sequencer #(
   parameter int WORD_LENGTH = 16,
   parameter int NUM_CLIPS   = 4,
   parameter int CLIP_DEPTH  = 131072,
   localparam int AW         = $clog2(CLIP_DEPTH),
   localparam int CW         = $clog2(NUM_CLIPS)
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   play_i,
   input  logic                   record_i,
   input  logic                   stop_i,
   input  logic                   loop_i,
   input  logic                   play_clip_select_i,
   input  logic                   record_clip_select_i,
   input  logic                   sample_done_i,
   input  logic [WORD_LENGTH-1:0] sample_i,
   output logic                   serializer_enable_o,
   output logic                   deserializer_enable_o,
   output logic [NUM_CLIPS-1:0]   mem_enable_o,
   output logic                   mem_we_o,
   output logic [AW-1:0]          mem_addr_o,
   output logic [WORD_LENGTH-1:0] mem_wdata_o,
   output logic [CW-1:0]          play_clip_o,
   output logic [CW-1:0]          record_clip_o,
   output logic                   playing_o,
   output logic                   recording_o,
   output logic [NUM_CLIPS-1:0]   clip_valid_o,
   output logic                   done_o
);

   // state     | meaning
   // ST_IDLE   | no memory access, waiting for record/play command
   // ST_RECORD | writing samples into record_clip at addr_q
   // ST_PLAY   | reading samples from play_clip at addr_q
   typedef enum logic [1:0] {ST_IDLE, ST_RECORD, ST_PLAY} state_t;

   localparam int LW = AW + 1;

   state_t         state_q, state_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [CW-1:0]  play_clip_q, play_clip_d;
   logic [CW-1:0]  record_clip_q, record_clip_d;
   logic           done_q, done_d;
   logic [LW-1:0]  len_q [NUM_CLIPS];
   logic [LW-1:0]  len_d [NUM_CLIPS];

   logic play_prev_q, record_prev_q, stop_prev_q, psel_prev_q, rsel_prev_q;
   logic play_edge, record_edge, stop_edge, psel_edge, rsel_edge;
   logic wr_fire, last_wr, play_last;
   logic [LW-1:0] written;

   assign play_edge   = play_i & ~play_prev_q;
   assign record_edge = record_i & ~record_prev_q;
   assign stop_edge   = stop_i & ~stop_prev_q;
   assign psel_edge   = play_clip_select_i & ~psel_prev_q;
   assign rsel_edge   = record_clip_select_i & ~rsel_prev_q;

   assign wr_fire   = (state_q == ST_RECORD) && sample_done_i;
   // a sample arriving alongside a stop still counts toward the length
   assign written   = {1'b0, addr_q} + LW'(wr_fire);
   assign last_wr   = wr_fire && (addr_q == AW'(CLIP_DEPTH - 1));
   assign play_last = (({1'b0, addr_q} + LW'(1)) == len_q[play_clip_q]);

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      done_d        = 1'b0;
      play_clip_d   = play_clip_q;
      record_clip_d = record_clip_q;
      len_d         = len_q;

      if (rsel_edge && state_q != ST_RECORD)
         record_clip_d = (record_clip_q == CW'(NUM_CLIPS - 1)) ? '0 : record_clip_q + CW'(1);
      if (psel_edge && state_q != ST_PLAY)
         play_clip_d = (play_clip_q == CW'(NUM_CLIPS - 1)) ? '0 : play_clip_q + CW'(1);

      case (state_q)
         ST_IDLE: begin
            if (stop_edge) begin
               state_d = ST_IDLE;
            end else if (record_edge) begin
               state_d = ST_RECORD;
               addr_d  = '0;
            end else if (play_edge && len_q[play_clip_q] != '0) begin
               state_d = ST_PLAY;
               addr_d  = '0;
            end
         end
         ST_RECORD: begin
            if (stop_edge || record_edge) begin
               len_d[record_clip_q] = written;
               state_d              = ST_IDLE;
               addr_d               = '0;
            end else if (last_wr) begin
               len_d[record_clip_q] = LW'(CLIP_DEPTH);
               done_d               = 1'b1;
               state_d              = ST_IDLE;
               addr_d               = '0;
            end else if (wr_fire) begin
               addr_d = addr_q + AW'(1);
            end
         end
         ST_PLAY: begin
            if (stop_edge) begin
               state_d = ST_IDLE;
               addr_d  = '0;
            end else if (record_edge) begin
               state_d = ST_RECORD;
               addr_d  = '0;
            end else if (play_edge) begin
               addr_d = '0;
            end else if (sample_done_i) begin
               if (play_last) begin
                  addr_d = '0;
                  if (!loop_i) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else begin
                  addr_d = addr_q + AW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            addr_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         play_clip_q   <= '0;
         record_clip_q <= '0;
         done_q        <= 1'b0;
         play_prev_q   <= 1'b0;
         record_prev_q <= 1'b0;
         stop_prev_q   <= 1'b0;
         psel_prev_q   <= 1'b0;
         rsel_prev_q   <= 1'b0;
         for (int i = 0; i < NUM_CLIPS; i++) len_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         play_clip_q   <= play_clip_d;
         record_clip_q <= record_clip_d;
         done_q        <= done_d;
         play_prev_q   <= play_i;
         record_prev_q <= record_i;
         stop_prev_q   <= stop_i;
         psel_prev_q   <= play_clip_select_i;
         rsel_prev_q   <= record_clip_select_i;
         for (int i = 0; i < NUM_CLIPS; i++) len_q[i] <= len_d[i];
      end
   end

   always_comb begin
      mem_enable_o = '0;
      if (state_q == ST_RECORD)
         mem_enable_o = NUM_CLIPS'(1) << record_clip_q;
      else if (state_q == ST_PLAY)
         mem_enable_o = NUM_CLIPS'(1) << play_clip_q;
   end

   always_comb begin
      clip_valid_o = '0;
      for (int i = 0; i < NUM_CLIPS; i++) clip_valid_o[i] = (len_q[i] != '0);
   end

   assign serializer_enable_o   = (state_q == ST_PLAY);
   assign deserializer_enable_o = (state_q == ST_RECORD);
   assign playing_o             = (state_q == ST_PLAY);
   assign recording_o           = (state_q == ST_RECORD);
   assign mem_we_o              = wr_fire;
   assign mem_wdata_o           = wr_fire ? sample_i : '0;
   assign mem_addr_o            = addr_q;
   assign play_clip_o           = play_clip_q;
   assign record_clip_o         = record_clip_q;
   assign done_o                = done_q;

endmodule

// File: tb/tb_clip_sequencer.sv
// Scoreboard bench for clip_sequencer: stimulus pushes expected memory/done events,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_clip_sequencer;
   localparam int WL = 16, NC = 4, DEPTH = 8, AW = 3, CW = 2;
   localparam logic [1:0] K_WR = 2'd1, K_RD = 2'd2, K_DONE = 2'd3;

   typedef struct packed {
      logic [1:0]    kind;
      logic [NC-1:0] en;
      logic [AW-1:0] addr;
      logic [WL-1:0] data;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_i = 1'b1, play_i = 1'b0, record_i = 1'b0, stop_i = 1'b0, loop_i = 1'b0;
   logic psel_i = 1'b0, rsel_i = 1'b0, sample_done_i = 1'b0;
   logic [WL-1:0] sample_i = '0;
   logic ser_en, des_en, mem_we, playing, recording, done;
   logic [NC-1:0] mem_en, clip_valid;
   logic [AW-1:0] mem_addr;
   logic [WL-1:0] mem_wdata;
   logic [CW-1:0] play_clip, record_clip;

   clip_sequencer #(.WORD_LENGTH(WL), .NUM_CLIPS(NC), .CLIP_DEPTH(DEPTH)) dut (
      .clock_i(clk), .reset_i(reset_i), .play_i(play_i), .record_i(record_i),
      .stop_i(stop_i), .loop_i(loop_i), .play_clip_select_i(psel_i),
      .record_clip_select_i(rsel_i), .sample_done_i(sample_done_i), .sample_i(sample_i),
      .serializer_enable_o(ser_en), .deserializer_enable_o(des_en), .mem_enable_o(mem_en),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .play_clip_o(play_clip), .record_clip_o(record_clip), .playing_o(playing),
      .recording_o(recording), .clip_valid_o(clip_valid), .done_o(done)
   );

   int n_checks = 0, n_fail = 0;
   ev_t exp_q[$];
   ev_t mon_ev;
   int m_len[NC];
   int m_pc = 0, m_rc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic obs(input ev_t a);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: kind %0d en %b addr %0d data %h at %0t",
                  a.kind, a.en, a.addr, a.data, $time);
      end else begin
         e = exp_q.pop_front();
         if (a !== e) begin
            n_fail++;
            $display("FAIL event: got kind %0d en %b addr %0d data %h, expected kind %0d en %b addr %0d data %h at %0t",
                     a.kind, a.en, a.addr, a.data, e.kind, e.en, e.addr, e.data, $time);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset_i) begin
         if (mem_we) begin
            mon_ev = '{kind: K_WR, en: mem_en, addr: mem_addr, data: mem_wdata};
            obs(mon_ev);
         end
         if (playing && sample_done_i) begin
            mon_ev = '{kind: K_RD, en: mem_en, addr: mem_addr, data: '0};
            obs(mon_ev);
         end
         if (done) begin
            mon_ev = '{kind: K_DONE, en: '0, addr: '0, data: '0};
            obs(mon_ev);
         end
      end
   end

   function automatic logic [NC-1:0] model_valid();
      logic [NC-1:0] v;
      v = '0;
      for (int i = 0; i < NC; i++) v[i] = (m_len[i] != 0);
      return v;
   endfunction

   function automatic logic [NC-1:0] onehot(input int idx);
      logic [NC-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int which, input logic v);
      case (which)
         0: play_i = v;
         1: record_i = v;
         2: stop_i = v;
         3: psel_i = v;
         default: rsel_i = v;
      endcase
   endtask

   task automatic cmd(input int which);
      set_cmd(which, 1'b1);
      tick();
      set_cmd(which, 1'b0);
      tick();
   endtask

   task automatic sample(input logic [WL-1:0] d, input bit with_stop);
      sample_i = d;
      sample_done_i = 1'b1;
      if (with_stop) stop_i = 1'b1;
      tick();
      sample_done_i = 1'b0;
      stop_i = 1'b0;
      sample_i = WL'($urandom);
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic check_idle(input string tag);
      tick();
      tick();
      @(negedge clk);
      check({tag, "_playing"}, 32'(playing), 32'(0));
      check({tag, "_recording"}, 32'(recording), 32'(0));
      check({tag, "_mem_en"}, 32'(mem_en), 32'(0));
      check({tag, "_valid"}, 32'(clip_valid), 32'(model_valid()));
      check({tag, "_play_clip"}, 32'(play_clip), 32'(m_pc));
      check({tag, "_rec_clip"}, 32'(record_clip), 32'(m_rc));
   endtask

   // endk: 0 stop edge, 1 record edge, 2 stop together with the last sample
   task automatic do_record(input int n, input int endk, input logic [WL-1:0] base);
      logic [WL-1:0] d;
      logic [NC-1:0] en;
      cmd(1);
      en = onehot(m_rc);
      for (int i = 0; i < n; i++) begin
         d = (base != '0) ? WL'(base * (i + 1)) : WL'($urandom);
         exp_q.push_back('{kind: K_WR, en: en, addr: AW'(i), data: d});
         if (i == DEPTH - 1) exp_q.push_back('{kind: K_DONE, en: '0, addr: '0, data: '0});
         sample(d, (i == n - 1) && (endk == 2) && (n < DEPTH));
         if (i < n - 1 && $urandom_range(0, 3) == 0) cmd(4);
      end
      if (n < DEPTH) begin
         if (endk == 1) cmd(1);
         else if (endk == 0 || n == 0) cmd(2);
      end
      m_len[m_rc] = n;
   endtask

   task automatic do_play(input int k, input bit lp, input int restart_at, input bit endstop);
      int len, pos;
      bit finished;
      logic [NC-1:0] en;
      loop_i = lp;
      cmd(0);
      len = m_len[m_pc];
      if (len == 0) begin
         @(negedge clk);
         check("empty_play_playing", 32'(playing), 32'(0));
         check("empty_play_mem_en", 32'(mem_en), 32'(0));
      end else begin
         en = onehot(m_pc);
         pos = 0;
         finished = 1'b0;
         for (int i = 0; i < k; i++) begin
            if (i == restart_at) begin
               cmd(0);
               pos = 0;
            end
            exp_q.push_back('{kind: K_RD, en: en, addr: AW'(pos % len), data: '0});
            if (!lp && pos == len - 1) begin
               exp_q.push_back('{kind: K_DONE, en: '0, addr: '0, data: '0});
               sample(WL'($urandom), 1'b0);
               finished = 1'b1;
               break;
            end
            sample(WL'($urandom), 1'b0);
            pos++;
            if (i < k - 1 && $urandom_range(0, 3) == 0) cmd(3);
         end
         if (!finished && endstop) cmd(2);
      end
      loop_i = 1'b0;
   endtask

   initial begin
      logic [NC-1:0] en;
      int n, len;
      for (int i = 0; i < NC; i++) m_len[i] = 0;
      repeat (3) tick();
      @(negedge clk);
      check("reset_outputs", 32'({ser_en, des_en, mem_en, mem_we, mem_addr, mem_wdata, done}), 32'(0));
      reset_i = 1'b0;
      check_idle("reset");

      // record three fixed samples on clip 2, then stop
      cmd(4); cmd(4); m_rc = 2;
      do_record(3, 0, 16'h1111);
      check_idle("rec3");
      check("rec3_valid_const", 32'(clip_valid), 32'(4'b0100));

      // play clip 2 once, then looped
      cmd(3); cmd(3); m_pc = 2;
      do_play(3, 1'b0, -1, 1'b1);
      check_idle("play3");
      do_play(7, 1'b1, -1, 1'b1);
      check_idle("loop7");

      // full-depth recording on clip 0
      cmd(4); cmd(4); m_rc = 0;
      do_record(DEPTH, 0, '0);
      check_idle("rec_full");

      // play edge on empty clip 3
      cmd(3); m_pc = 3;
      do_play(1, 1'b0, -1, 1'b1);
      check_idle("empty");

      // play and record edges together: record wins
      play_i = 1'b1; record_i = 1'b1;
      tick();
      play_i = 1'b0; record_i = 1'b0;
      @(negedge clk);
      check("play_rec_same_cycle", 32'({recording, playing}), 32'(2'b10));
      tick();
      cmd(2);
      m_len[m_rc] = 0;
      check_idle("zero_rec");

      // abort playback of clip 2 by recording onto clip 0
      cmd(3); cmd(3); cmd(3); m_pc = 2;
      do_play(2, 1'b0, -1, 1'b0);
      do_record(2, 2, '0);
      check_idle("abort");

      for (int op = 0; op < 40; op++) begin
         case ($urandom_range(0, 4))
            0: begin
               if ($urandom_range(0, 1) == 1) begin cmd(3); m_pc = (m_pc + 1) % NC; end
               else begin cmd(4); m_rc = (m_rc + 1) % NC; end
            end
            1: do_record($urandom_range(0, DEPTH), $urandom_range(0, 2), '0);
            2: begin
               len = (m_len[m_pc] == 0) ? 1 : m_len[m_pc];
               do_play($urandom_range(1, 2 * len + 2), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 2) == 0) ? 1 : -1, 1'b1);
            end
            3: begin
               len = (m_len[m_pc] == 0) ? 1 : m_len[m_pc];
               do_play($urandom_range(1, len), 1'b1, -1, 1'b0);
               do_record($urandom_range(0, DEPTH), $urandom_range(0, 2), '0);
            end
            default: tick();
         endcase
         check_idle("rand");
      end

      // reset in the middle of a recording
      cmd(1);
      en = onehot(m_rc);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{kind: K_WR, en: en, addr: AW'(i), data: 16'h00a0 + WL'(i)});
         sample(16'h00a0 + WL'(i), 1'b0);
      end
      reset_i = 1'b1;
      tick();
      @(negedge clk);
      check("midrec_reset_outputs",
            32'({ser_en, des_en, mem_en, mem_we, mem_addr, mem_wdata, done, playing, recording}), 32'(0));
      for (int i = 0; i < NC; i++) m_len[i] = 0;
      m_pc = 0; m_rc = 0;
      reset_i = 1'b0;
      check_idle("midrec_reset");

      n = exp_q.size();
      check("scoreboard_drained", 32'(n), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
